// File: rtl/arp_lookup_arb_if.sv
// Bundle of the requester-side and ARP-table-side signals of the lookup arbiter.
// The arbiter connects through the slave modport. Requesters and the table
// connect through the master modport.
interface arp_lookup_arb_if #(
  parameter int N_REQ = 4
);
  logic [N_REQ-1:0]    req_en;
  logic [32*N_REQ-1:0] req_ip;
  logic [24*N_REQ-1:0] req_netport;
  logic [47:0]         resp_mac;
  logic [N_REQ-1:0]    resp_hit_en;
  logic [N_REQ-1:0]    resp_del_en;
  logic [31:0]         tbl_ip_dout;
  logic [23:0]         tbl_netport_dout;
  logic                tbl_req_en;
  logic [47:0]         tbl_mac_din;
  logic                tbl_mac_din_en;
  logic                tbl_del_din_en;

  modport master (
    output req_en, req_ip, req_netport, tbl_mac_din, tbl_mac_din_en, tbl_del_din_en,
    input  resp_mac, resp_hit_en, resp_del_en, tbl_ip_dout, tbl_netport_dout, tbl_req_en
  );

  modport slave (
    input  req_en, req_ip, req_netport, tbl_mac_din, tbl_mac_din_en, tbl_del_din_en,
    output resp_mac, resp_hit_en, resp_del_en, tbl_ip_dout, tbl_netport_dout, tbl_req_en
  );
endinterface

// File: rtl/arp_lookup_arb.sv
// Round-robin arbiter sharing one ARP table lookup port among N_REQ engines.
// One lookup is outstanding at a time. A silent table is turned into a delete
// response after TIMEOUT_CYC cycles, so requesters never hang.
//
// state     | meaning
// ARB_IDLE  | no lookup outstanding; grant the next pending requester
// ARB_ISSUE | strobe the latched IP/netport to the table
// ARB_WAIT  | wait for a hit/delete strobe or for the timeout
// ARB_RESP  | one-cycle hit or delete pulse to the granted requester
module arp_lookup_arb #(
  parameter int N_REQ       = 4,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                   clk,
  input  logic                   rst,
  arp_lookup_arb_if.slave        bus,
  output logic                   busy,
  output logic [15:0]            timeout_cnt
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_WAIT  = 2'd2,
    ARB_RESP  = 2'd3
  } arb_state_t;

  arb_state_t       state_q, state_d;
  logic [N_REQ-1:0] pending_q;
  logic [N_REQ-1:0] clr_mask;
  logic [IDX_W-1:0] rr_q;
  logic [IDX_W-1:0] gnt_q;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_valid;
  logic             take_grant;
  logic             ans_hit;
  logic             ans_del;
  logic             ans_tmo;
  logic             is_hit_q;
  logic [31:0]      ip_q;
  logic [23:0]      np_q;
  logic [47:0]      mac_q;
  logic [15:0]      wait_q;

  // Round-robin pick: first pending requester at or after the rr pointer.
  always_comb begin
    int idx;
    idx        = 0;
    pick_valid = 1'b0;
    pick_idx   = '0;
    // Scan from the farthest candidate back so the closest one wins.
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = (int'(rr_q) + k) % N_REQ;
      if (pending_q[idx]) begin
        pick_valid = 1'b1;
        pick_idx   = idx[IDX_W-1:0];
      end
    end
  end

  // Next-state decode; a delete strobe wins over a simultaneous hit strobe.
  always_comb begin
    state_d    = state_q;
    take_grant = 1'b0;
    ans_hit    = 1'b0;
    ans_del    = 1'b0;
    ans_tmo    = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        if (pick_valid) begin
          take_grant = 1'b1;
          state_d    = ARB_ISSUE;
        end
      end
      ARB_ISSUE: state_d = ARB_WAIT;
      ARB_WAIT: begin
        if (bus.tbl_del_din_en) begin
          ans_del = 1'b1;
          state_d = ARB_RESP;
        end else if (bus.tbl_mac_din_en) begin
          ans_hit = 1'b1;
          state_d = ARB_RESP;
        end else if (wait_q == TMO_LAST) begin
          ans_tmo = 1'b1;
          state_d = ARB_RESP;
        end
      end
      ARB_RESP: state_d = ARB_IDLE;
      default:  state_d = ARB_IDLE;
    endcase
  end

  // Pending bit of the requester being granted this cycle.
  always_comb begin
    clr_mask = '0;
    if (take_grant) clr_mask[pick_idx] = 1'b1;
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ARB_IDLE;
    else      state_q <= state_d;
  end

  // Pending capture; a fresh request in the grant cycle is kept for a later lookup.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) pending_q <= '0;
    else      pending_q <= (pending_q & ~clr_mask) | bus.req_en;
  end

  // Grant latch, rr pointer advance and table request payload.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_q  <= '0;
      gnt_q <= '0;
      ip_q  <= '0;
      np_q  <= '0;
    end else if (take_grant) begin
      gnt_q <= pick_idx;
      ip_q  <= bus.req_ip[32*pick_idx +: 32];
      np_q  <= bus.req_netport[24*pick_idx +: 24];
      if (int'(pick_idx) == N_REQ - 1) rr_q <= '0;
      else                             rr_q <= pick_idx + 1'b1;
    end
  end

  // Wait counter: cleared on issue, counts every cycle spent waiting.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                       wait_q <= '0;
    else if (state_q == ARB_ISSUE)  wait_q <= '0;
    else if (state_q == ARB_WAIT)   wait_q <= wait_q + 16'd1;
  end

  // Answer latch: hit/delete kind and the MAC of a hit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      is_hit_q <= 1'b0;
      mac_q    <= '0;
    end else if (state_q == ARB_WAIT) begin
      is_hit_q <= ans_hit;
      if (ans_hit) mac_q <= bus.tbl_mac_din;
    end
  end

  // Saturating count of forced-delete timeouts.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                  timeout_cnt <= '0;
    else if (ans_tmo && timeout_cnt != 16'hFFFF) timeout_cnt <= timeout_cnt + 16'd1;
  end

  // Response pulse routed only to the granted requester.
  always_comb begin
    bus.resp_hit_en = '0;
    bus.resp_del_en = '0;
    if (state_q == ARB_RESP) begin
      if (is_hit_q) bus.resp_hit_en[gnt_q] = 1'b1;
      else          bus.resp_del_en[gnt_q] = 1'b1;
    end
  end

  assign bus.resp_mac         = mac_q;
  assign bus.tbl_ip_dout      = ip_q;
  assign bus.tbl_netport_dout = np_q;
  assign bus.tbl_req_en       = (state_q == ARB_ISSUE);
  assign busy                 = (state_q != ARB_IDLE);

endmodule

// File: tb/tb_arp_lookup_arb.sv
// Directed bench for the ARP lookup arbiter (N_REQ=4, TIMEOUT_CYC=8).
module tb_arp_lookup_arb;
  logic        clk = 1'b0;
  logic        rst;
  logic        busy;
  logic [15:0] timeout_cnt;
  int          pass_cnt  = 0;
  int          total_cnt = 0;
  int          cyc       = 0;

  arp_lookup_arb_if #(.N_REQ(4)) bus ();

  arp_lookup_arb #(.N_REQ(4), .TIMEOUT_CYC(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .busy        (busy),
    .timeout_cnt (timeout_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_default_ips;
    for (int i = 0; i < 4; i++) begin
      bus.req_ip[32*i +: 32]      = 32'h0A00_0000 | 32'(i);
      bus.req_netport[24*i +: 24] = 24'h000100 | 24'(i);
    end
  endtask

  task automatic do_reset;
    rst                = 1'b0;
    bus.req_en         = '0;
    bus.tbl_mac_din    = '0;
    bus.tbl_mac_din_en = 1'b0;
    bus.tbl_del_din_en = 1'b0;
    set_default_ips();
    tick(); tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic pulse_req(input logic [3:0] r);
    bus.req_en = r;
    tick();
    bus.req_en = '0;
  endtask

  // Bounded wait for the table strobe; ok=0 if it never comes.
  task automatic wait_req(output bit ok, output int c);
    ok = 1'b0;
    c  = cyc;
    for (int k = 0; k < 40; k++) begin
      if (bus.tbl_req_en === 1'b1) begin
        ok = 1'b1;
        c  = cyc;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset;
    rst                = 1'b0;
    bus.req_en         = '0;
    bus.tbl_mac_din    = '0;
    bus.tbl_mac_din_en = 1'b0;
    bus.tbl_del_din_en = 1'b0;
    set_default_ips();
    tick(); tick();
    total_cnt++;
    if ({bus.tbl_req_en, bus.resp_hit_en, bus.resp_del_en, busy} !== 10'd0)
      $display("FAIL reset_ctrl: got %b required 0", {bus.tbl_req_en, bus.resp_hit_en, bus.resp_del_en, busy});
    else pass_cnt++;
    total_cnt++;
    if ({bus.tbl_ip_dout, bus.tbl_netport_dout, bus.resp_mac, timeout_cnt} !== 120'd0)
      $display("FAIL reset_data: got ip=%h np=%h mac=%h tmo=%0d required all 0",
               bus.tbl_ip_dout, bus.tbl_netport_dout, bus.resp_mac, timeout_cnt);
    else pass_cnt++;
    rst = 1'b1;
    begin
      bit seen;
      seen = 1'b0;
      for (int k = 0; k < 12; k++) begin
        tick();
        seen |= bus.tbl_req_en | busy;
      end
      total_cnt++;
      if (seen !== 1'b0) $display("FAIL reset_idle: got activity=%b required 0", seen);
      else pass_cnt++;
    end
  endtask

  task automatic test_single;
    do_reset();
    bus.req_ip[63:32]      = 32'hC0A8_0105;
    bus.req_netport[47:24] = 24'h000003;
    pulse_req(4'b0010);                       // now cycle 1
    total_cnt++;
    if (bus.tbl_req_en !== 1'b0) $display("FAIL single_c1_req: got %b required 0", bus.tbl_req_en);
    else pass_cnt++;
    tick();                                   // cycle 2
    total_cnt++;
    if (bus.tbl_req_en !== 1'b1) $display("FAIL single_c2_req: got %b required 1", bus.tbl_req_en);
    else pass_cnt++;
    total_cnt++;
    if (bus.tbl_ip_dout !== 32'hC0A8_0105 || bus.tbl_netport_dout !== 24'h000003)
      $display("FAIL single_payload: got ip=%h np=%h required ip=c0a80105 np=000003",
               bus.tbl_ip_dout, bus.tbl_netport_dout);
    else pass_cnt++;
    tick();                                   // cycle 3
    total_cnt++;
    if (bus.tbl_req_en !== 1'b0 || busy !== 1'b1)
      $display("FAIL single_c3: got req=%b busy=%b required req=0 busy=1", bus.tbl_req_en, busy);
    else pass_cnt++;
    tick(); tick();                           // cycle 5
    bus.tbl_mac_din    = 48'h0011_2233_4455;
    bus.tbl_mac_din_en = 1'b1;
    tick();                                   // cycle 6
    bus.tbl_mac_din_en = 1'b0;
    total_cnt++;
    if (bus.resp_hit_en !== 4'b0010 || bus.resp_del_en !== 4'b0000)
      $display("FAIL single_resp: got hit=%b del=%b required hit=0010 del=0000",
               bus.resp_hit_en, bus.resp_del_en);
    else pass_cnt++;
    total_cnt++;
    if (bus.resp_mac !== 48'h0011_2233_4455)
      $display("FAIL single_mac: got %h required 001122334455", bus.resp_mac);
    else pass_cnt++;
    tick();                                   // cycle 7
    total_cnt++;
    if (bus.resp_hit_en !== 4'b0000 || busy !== 1'b0)
      $display("FAIL single_after: got hit=%b busy=%b required hit=0000 busy=0", bus.resp_hit_en, busy);
    else pass_cnt++;
  endtask

  task automatic test_all_four;
    int          prev;
    int          c;
    bit          ok;
    logic [3:0]  exp_bit;
    do_reset();
    pulse_req(4'b1111);
    prev = -100;
    for (int i = 0; i < 4; i++) begin
      wait_req(ok, c);
      total_cnt++;
      if (ok !== 1'b1) $display("FAIL all4_wait%0d: got no tbl_req_en required one", i);
      else pass_cnt++;
      total_cnt++;
      if (bus.tbl_ip_dout !== (32'h0A00_0000 | 32'(i)))
        $display("FAIL all4_grant%0d: got ip=%h required %h", i, bus.tbl_ip_dout, 32'h0A00_0000 | 32'(i));
      else pass_cnt++;
      if (i > 0) begin
        total_cnt++;
        if ((c - prev) < 4) $display("FAIL all4_spacing%0d: got %0d required >=4", i, c - prev);
        else pass_cnt++;
      end
      prev = c;
      tick(); tick(); tick();
      bus.tbl_mac_din    = 48'hA0_0000_0000 | 48'(i);
      bus.tbl_mac_din_en = 1'b1;
      tick();
      bus.tbl_mac_din_en = 1'b0;
      exp_bit = 4'b0001 << i;
      total_cnt++;
      if (bus.resp_hit_en !== exp_bit || bus.resp_del_en !== 4'b0000 ||
          bus.resp_mac !== (48'hA0_0000_0000 | 48'(i)))
        $display("FAIL all4_resp%0d: got hit=%b del=%b mac=%h required hit=%b del=0000 mac=%h",
                 i, bus.resp_hit_en, bus.resp_del_en, bus.resp_mac, exp_bit, 48'hA0_0000_0000 | 48'(i));
      else pass_cnt++;
      tick();
    end
  endtask

  task automatic test_fairness;
    int         exp_g [4];
    int         g;
    int         prev_g;
    int         c;
    bit         ok;
    logic [3:0] exp_bit;
    exp_g = '{0, 2, 0, 2};
    do_reset();
    pulse_req(4'b0101);
    prev_g = -1;
    for (int n = 0; n < 4; n++) begin
      wait_req(ok, c);
      g = int'(bus.tbl_ip_dout[3:0]);
      total_cnt++;
      if (ok !== 1'b1 || g != exp_g[n])
        $display("FAIL fair_grant%0d: got ok=%b g=%0d required ok=1 g=%0d", n, ok, g, exp_g[n]);
      else pass_cnt++;
      total_cnt++;
      if (g == prev_g) $display("FAIL fair_repeat%0d: got g=%0d twice required alternation", n, g);
      else pass_cnt++;
      prev_g = g;
      tick(); tick();
      bus.tbl_mac_din    = 48'h00BB_0000_0000 | 48'(n);
      bus.tbl_mac_din_en = 1'b1;
      tick();
      bus.tbl_mac_din_en = 1'b0;
      exp_bit = 4'b0001 << exp_g[n];
      total_cnt++;
      if (bus.resp_hit_en !== exp_bit)
        $display("FAIL fair_resp%0d: got hit=%b required %b", n, bus.resp_hit_en, exp_bit);
      else pass_cnt++;
      if (n < 2) bus.req_en = exp_bit;
      tick();
      bus.req_en = '0;
    end
    tick(); tick();
    total_cnt++;
    if (busy !== 1'b0) $display("FAIL fair_drain: got busy=%b required 0", busy);
    else pass_cnt++;
  endtask

  task automatic test_both_strobes;
    int c;
    bit ok;
    do_reset();
    pulse_req(4'b0001);
    wait_req(ok, c);
    tick(); tick();
    bus.tbl_mac_din    = 48'h0A0B_0C0D_0E0F;
    bus.tbl_mac_din_en = 1'b1;
    tick();
    bus.tbl_mac_din_en = 1'b0;
    total_cnt++;
    if (bus.resp_hit_en !== 4'b0001) $display("FAIL both_prime: got hit=%b required 0001", bus.resp_hit_en);
    else pass_cnt++;
    tick();
    pulse_req(4'b0100);
    wait_req(ok, c);
    total_cnt++;
    if (ok !== 1'b1) $display("FAIL both_wait: got no tbl_req_en required one");
    else pass_cnt++;
    tick();
    bus.tbl_mac_din    = 48'hFFEE_DDCC_BBAA;
    bus.tbl_mac_din_en = 1'b1;
    bus.tbl_del_din_en = 1'b1;
    tick();
    bus.tbl_mac_din_en = 1'b0;
    bus.tbl_del_din_en = 1'b0;
    total_cnt++;
    if (bus.resp_del_en !== 4'b0100 || bus.resp_hit_en !== 4'b0000)
      $display("FAIL both_resp: got hit=%b del=%b required hit=0000 del=0100", bus.resp_hit_en, bus.resp_del_en);
    else pass_cnt++;
    total_cnt++;
    if (bus.resp_mac !== 48'h0A0B_0C0D_0E0F)
      $display("FAIL both_mac: got %h required 0a0b0c0d0e0f", bus.resp_mac);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (bus.resp_del_en !== 4'b0000) $display("FAIL both_once: got del=%b required 0000", bus.resp_del_en);
    else pass_cnt++;
  endtask

  task automatic test_timeout;
    int         c;
    bit         ok;
    logic [3:0] seen;
    do_reset();
    pulse_req(4'b1000);
    wait_req(ok, c);
    total_cnt++;
    if (ok !== 1'b1 || bus.tbl_ip_dout !== 32'h0A00_0003)
      $display("FAIL tmo_issue: got ok=%b ip=%h required ok=1 ip=0a000003", ok, bus.tbl_ip_dout);
    else pass_cnt++;
    for (int k = 0; k < 8; k++) tick();       // tbl_req_en + 8
    total_cnt++;
    if (bus.resp_del_en !== 4'b0000 || busy !== 1'b1)
      $display("FAIL tmo_early: got del=%b busy=%b required del=0000 busy=1", bus.resp_del_en, busy);
    else pass_cnt++;
    tick();                                   // tbl_req_en + 9
    total_cnt++;
    if (bus.resp_del_en !== 4'b1000 || bus.resp_hit_en !== 4'b0000)
      $display("FAIL tmo_resp: got hit=%b del=%b required hit=0000 del=1000", bus.resp_hit_en, bus.resp_del_en);
    else pass_cnt++;
    total_cnt++;
    if (timeout_cnt !== 16'd1) $display("FAIL tmo_count: got %0d required 1", timeout_cnt);
    else pass_cnt++;
    tick(); tick();                           // late answer 2 cycles after the delete
    bus.tbl_mac_din    = 48'h1234_5678_9ABC;
    bus.tbl_mac_din_en = 1'b1;
    tick();
    bus.tbl_mac_din_en = 1'b0;
    seen = '0;
    for (int k = 0; k < 4; k++) begin
      seen |= bus.resp_hit_en | bus.resp_del_en;
      tick();
    end
    total_cnt++;
    if (seen !== 4'b0000 || busy !== 1'b0)
      $display("FAIL tmo_late: got pulses=%b busy=%b required 0000 busy=0", seen, busy);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid;
    int c;
    bit ok;
    bit seen;
    do_reset();
    pulse_req(4'b0001);
    wait_req(ok, c);
    tick();
    bus.req_en = 4'b0110;
    tick();
    bus.req_en = '0;
    total_cnt++;
    if (busy !== 1'b1) $display("FAIL rmid_busy: got %b required 1", busy);
    else pass_cnt++;
    rst = 1'b0;
    #1;
    total_cnt++;
    if ({bus.tbl_req_en, bus.resp_hit_en, bus.resp_del_en, busy} !== 10'd0)
      $display("FAIL rmid_ctrl: got %b required 0", {bus.tbl_req_en, bus.resp_hit_en, bus.resp_del_en, busy});
    else pass_cnt++;
    total_cnt++;
    if ({bus.tbl_ip_dout, bus.tbl_netport_dout} !== 56'd0)
      $display("FAIL rmid_data: got ip=%h np=%h required 0", bus.tbl_ip_dout, bus.tbl_netport_dout);
    else pass_cnt++;
    tick(); tick();
    rst  = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 15; k++) begin
      tick();
      seen |= bus.tbl_req_en | busy | (|bus.resp_hit_en) | (|bus.resp_del_en);
    end
    total_cnt++;
    if (seen !== 1'b0) $display("FAIL rmid_dropped: got activity=%b required 0", seen);
    else pass_cnt++;
    pulse_req(4'b0010);
    tick();
    total_cnt++;
    if (bus.tbl_req_en !== 1'b1 || bus.tbl_ip_dout !== 32'h0A00_0001)
      $display("FAIL rmid_new: got req=%b ip=%h required req=1 ip=0a000001", bus.tbl_req_en, bus.tbl_ip_dout);
    else pass_cnt++;
    tick();
    bus.tbl_del_din_en = 1'b1;
    tick();
    bus.tbl_del_din_en = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_all_four();
    test_fairness();
    test_both_strobes();
    test_timeout();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/arp_lookup_arb.md
Name: arp_lookup_arb

Overview:
- Shares one ARP table lookup port among N_REQ packet-distribution engines. Each engine issues a one-cycle lookup request with a destination IP and a netport bitmap, then waits for either a MAC-hit or a delete/miss indication.
- The block queues the requests and grants them round-robin, one outstanding lookup at a time. It forwards the granted request to the ARP table and routes the table's answer back to the granted requester only.
- A per-lookup timeout turns a non-answering table into a delete response, so requesters never hang.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- TIMEOUT_CYC, 255, cycles to wait for a table answer before a forced delete (1..65535).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- req_en  in  N_REQ  per-requester one-cycle lookup request pulse.
- req_ip  in  32*N_REQ  requester i IP in bits [32i+31:32i]; held stable from req_en until that requester's response.
- req_netport  in  24*N_REQ  requester i netport bitmap in [24i+23:24i]; held stable likewise.
- resp_mac  out  48  MAC of the last hit; valid while any resp_hit_en bit is high.
- resp_hit_en  out  N_REQ  one-cycle hit pulse to the granted requester.
- resp_del_en  out  N_REQ  one-cycle delete/miss pulse to the granted requester.
- tbl_ip_dout  out  32  IP presented to the ARP table.
- tbl_netport_dout  out  24  netport presented to the ARP table.
- tbl_req_en  out  1  one-cycle lookup strobe to the table.
- tbl_mac_din  in  48  table MAC result.
- tbl_mac_din_en  in  1  table hit strobe.
- tbl_del_din_en  in  1  table miss/delete strobe.
- busy  out  1  high while a lookup is outstanding (state != ARB_IDLE).
- timeout_cnt  out  16  saturating count of forced-delete timeouts.

Behaviour:
- Reset (rst low, async): all outputs 0, pending vector 0, rr pointer 0, state ARB_IDLE, wait counter 0.
- Pending capture: on each cycle pending[i] <= pending[i] | req_en[i].
  - pending[i] clears in the cycle its grant is taken.
  - A req_en on an already-pending requester is absorbed; no second lookup is issued.
  - req_en from the requester currently in service sets pending again, which is a protocol violation. It is served again after the current lookup.
- Arbitration: round-robin starting at rr pointer. After a grant, rr = granted index + 1, modulo N_REQ.
- States:
  - ARB_IDLE: if any pending bit is set, pick grant g, latch g, req_ip[g] and req_netport[g], clear pending[g], go to ARB_ISSUE. Otherwise stay.
  - ARB_ISSUE: tbl_req_en = 1 for exactly this cycle; tbl_ip_dout/tbl_netport_dout carry the latched values (they stay held until next grant). Clear wait counter; go to ARB_WAIT.
  - ARB_WAIT: wait counter increments each cycle.
    - tbl_del_din_en = 1 (with or without tbl_mac_din_en): go to ARB_RESP with del. Delete has priority.
    - tbl_mac_din_en = 1 only: latch tbl_mac_din, go to ARB_RESP with hit.
    - Counter reaches TIMEOUT_CYC-1 with no strobe: go to ARB_RESP with del; timeout_cnt increments, saturating at 16'hFFFF.
  - ARB_RESP: for one cycle, resp_hit_en[g] or resp_del_en[g] = 1, all other bits 0, resp_mac = latched MAC (hit) or unchanged (del). Go to ARB_IDLE.
- Latency (idle arbiter): req_en at cycle 0 -> tbl_req_en at cycle 2. Table strobe at cycle t -> response pulse at cycle t+1.
- Minimum spacing between consecutive tbl_req_en pulses is 4 cycles.
- Table strobes arriving outside ARB_WAIT (late answer after timeout, spurious) are ignored and never produce a response.
- resp_hit_en and resp_del_en are never both high, and at most one bit of either is high in any cycle.
- Reset asserted mid-lookup: all pending requests and the outstanding lookup are dropped; no response pulse is generated.

Test Plan:
- Single request: req_en=4'b0010, IP 0xC0A80105, netport 0x000003; table hits at cycle 5 with MAC 0x001122334455 -> tbl_req_en at cycle 2 with that IP/netport; resp_hit_en=4'b0010 and resp_mac=0x001122334455 at cycle 6.
- All four requesters pulse in the same cycle, table hits after 3 cycles each -> grants in order 0,1,2,3; each response goes only to its own bit; tbl_req_en pulses at least 4 cycles apart.
- Fairness: requester 0 re-requests immediately after each of its responses while requester 2 is pending -> grants alternate 0,2,0,2; requester 0 is never granted twice in a row.
- Simultaneous tbl_mac_din_en and tbl_del_din_en in ARB_WAIT -> resp_del_en pulse only; resp_mac unchanged.
- Timeout with TIMEOUT_CYC=8: table never answers -> resp_del_en on the granted bit 9 cycles after tbl_req_en, timeout_cnt=1; a tbl_mac_din_en 2 cycles later -> no response pulse.
- Reset: drive rst low during ARB_WAIT with 2 requests pending -> all outputs 0 immediately. After release, no tbl_req_en until a new req_en arrives.
